macro_reduction_xor_accum: RTL and testbench
============================================

MACRO_REDUCTION_XOR_ACCUM -- requirements
Module: macro_reduction_xor_accum

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 1: width of one lane and of the result.
REQ-002 SHALL have parameter INPUT_COUNT, default 1: lanes per input beat.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the beat counter.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port clear  input  1: synchronous abort/flush.
REQ-007 SHALL have port s_valid  input  1: input beat valid.
REQ-008 SHALL have port s_ready  output  1: input beat accepted when high together with s_valid.
REQ-009 SHALL have port s_data  input  INPUT_WIDTH*INPUT_COUNT: packed lanes, lane i at bits [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-010 SHALL have port s_last  input  1: final beat of the frame.
REQ-011 SHALL have port m_valid  output  1: frame result valid.
REQ-012 SHALL have port m_ready  input  1: result consumed when high together with m_valid.
REQ-013 SHALL have port m_data  output  INPUT_WIDTH: XOR of all lanes of all beats in the frame.
REQ-014 SHALL have port m_beats  output  CNT_WIDTH: number of beats in the frame, saturating.

Function
REQ-015 Per-beat fold SHALL be the bitwise XOR of all INPUT_COUNT lanes of s_data (bit j = XOR of bit j of every lane).
REQ-016 SHALL implement two states: ACC (accumulating) and OUT (holding result).
REQ-017 In ACC: s_ready=1, m_valid=0; in OUT: s_ready=0, m_valid=1.
REQ-018 Beat accepted in ACC, s_last=0: acc <= acc ^ fold; cnt <= cnt+1, saturating at 2^CNT_WIDTH-1; stay in ACC.
REQ-019 Beat accepted in ACC, s_last=1: m_data <= acc ^ fold; m_beats <= cnt+1 (saturating); acc <= 0; cnt <= 0; go to OUT.
REQ-020 Latency: m_valid SHALL rise the cycle after the s_last beat is accepted.
REQ-021 A single-beat frame (s_last on the first beat) SHALL give m_data = fold of that beat and m_beats = 1.
REQ-022 In OUT, m_data and m_beats SHALL hold stable until handshake; m_valid SHALL NOT drop without m_ready, except on clear/reset.
REQ-023 In OUT with m_ready=1: return to ACC next cycle; no input beat is accepted in the handshake cycle.
REQ-024 s_data, s_last, and s_valid SHALL be ignored whenever s_ready=0.
REQ-025 clear=1 in any state SHALL set acc=0, cnt=0, state=ACC; any pending result is dropped and any beat presented that cycle is discarded.
REQ-026 clear SHALL take priority over a simultaneous input or output handshake.
REQ-027 When cnt is saturated, further beats SHALL still fold into acc, and cnt SHALL remain at all-ones.
REQ-028 The datapath SHALL NOT contain combinational paths from m_ready to s_ready or from s_valid to m_valid.

Reset
REQ-029 While reset=1 at a clock edge: state=ACC, acc=0, cnt=0, m_data=0, m_beats=0, m_valid=0, s_ready=1 the following cycle.
REQ-030 Reset mid-frame or while in OUT SHALL discard all partial and pending data; reset SHALL take priority over clear and over all handshakes.
REQ-031 All outputs SHALL be fully determined within one cycle of reset assertion; no X SHALL propagate to outputs after reset.

Verification (INPUT_WIDTH=4, INPUT_COUNT=2, CNT_WIDTH=2)
REQ-032 Two-beat frame: s_data=8'h3A, then 8'h5F with s_last=1 -> next cycle m_valid=1, m_data=4'h3, m_beats=2.
REQ-033 Single beat: 8'hC6 with s_last=1 -> m_data=4'hA, m_beats=1; hold m_ready=0 for 3 cycles -> outputs stable and s_ready=0 throughout.
REQ-034 Saturation: five beats of 8'h01, the last with s_last=1 -> m_data=4'h1, m_beats=2'b11.
REQ-035 Clear: 8'h3A accepted, then clear=1 with s_valid=1 and s_data=8'hFF, then 8'h10 with s_last=1 -> m_data=4'h1, m_beats=1.
REQ-036 Back-to-back frames: m_ready tied to 1, frames {8'h3A+last} and {8'h5F+last} -> results 4'h9 then 4'hA; no beat is accepted in either OUT cycle.
REQ-037 Reset in OUT: result pending, reset=1 for one cycle -> next cycle m_valid=0, m_data=0, s_ready=1; a subsequent frame {8'h5F+last} -> m_data=4'hA.

Source files
------------

// File: rtl/macro_reduction_xor_accum.sv
// Frame-wise XOR reduction: folds every lane of every beat into one word and counts beats.
// The result is held as a single registered output until the consumer accepts it.
module macro_reduction_xor_accum #(
  parameter int unsigned INPUT_WIDTH = 1,
  parameter int unsigned INPUT_COUNT = 1,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] s_data,
  input  logic                               s_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [INPUT_WIDTH-1:0]             m_data,
  output logic [CNT_WIDTH-1:0]               m_beats
);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] acc_q, acc_d;
  logic [INPUT_WIDTH-1:0] m_data_q, m_data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   m_beats_q, m_beats_d;
  logic [INPUT_WIDTH-1:0] fold;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  always_comb begin
    fold = '0;
    for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
      fold = fold ^ s_data[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // Beat count sticks at all-ones once saturated.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_beats_d = m_beats_q;
    unique case (state_q)
      StAcc: begin
        if (s_valid) begin
          if (s_last) begin
            m_data_d  = acc_q ^ fold;
            m_beats_d = cnt_inc;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = StOut;
          end else begin
            acc_d = acc_q ^ fold;
            cnt_d = cnt_inc;
          end
        end
      end
      StOut: begin
        if (m_ready) state_d = StAcc;
      end
      default: state_d = StAcc;
    endcase
    // Flush wins over any handshake; the held result word is left as-is but invalidated.
    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = StAcc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_beats_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_beats_q <= m_beats_d;
    end
  end

  assign s_ready = (state_q == StAcc);
  assign m_valid = (state_q == StOut);
  assign m_data  = m_data_q;
  assign m_beats = m_beats_q;

endmodule

// File: tb/tb_macro_reduction_xor_accum.sv
// Scoreboard bench: driver models frames as beat lists and queues expected results;
// a negedge monitor compares whatever the DUT presents against the queue head.
module tb_macro_reduction_xor_accum;

  localparam int IW = 4;
  localparam int IC = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [IW*IC-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [IW-1:0] m_data;
  logic [CW-1:0] m_beats;

  macro_reduction_xor_accum #(
    .INPUT_WIDTH(IW),
    .INPUT_COUNT(IC),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_beats(m_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] d;
    logic [CW-1:0] b;
  } res_t;

  res_t             exp_q[$];
  logic [IW*IC-1:0] frame[$];
  bit               busy = 1'b0;
  int               tests = 0;
  int               fails = 0;
  int               pushed = 0;
  int               dropped = 0;
  int               received = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result = XOR of every lane of every beat; beats = count clipped at 2^CW-1.
  function automatic res_t model_result();
    res_t r;
    int   n;
    logic [IW*IC-1:0] w;
    r.d = '0;
    foreach (frame[k]) begin
      w = frame[k];
      for (int l = 0; l < IC; l++) r.d = r.d ^ w[l*IW +: IW];
    end
    n   = frame.size();
    r.b = (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
    return r;
  endfunction

  // Drive one cycle; the model advances just after the negedge so the monitor sees prior state.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit mr,
                      input bit clr, input bit rst);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    clear   = clr;
    reset   = rst;
    @(negedge clk);
    #1;
    if (rst || clr) begin
      dropped += exp_q.size();
      exp_q.delete();
      frame.delete();
      busy = 1'b0;
    end else if (busy) begin
      if (mr) busy = 1'b0;
    end else if (v) begin
      frame.push_back(d);
      if (l) begin
        exp_q.push_back(model_result());
        frame.delete();
        pushed++;
        busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check("m_valid_vs_pending", 32'(m_valid), 32'(exp_q.size() != 0));
    check("s_ready_vs_m_valid", 32'(s_ready), 32'(!m_valid));
    if (m_valid === 1'b1 && exp_q.size() != 0) begin
      check("m_data", 32'(m_data), 32'(exp_q[0].d));
      check("m_beats", 32'(m_beats), 32'(exp_q[0].b));
      if (m_ready && !clear && !reset) begin
        void'(exp_q.pop_front());
        received++;
      end
    end
  end

  initial begin
    step(0, 8'h00, 0, 0, 0, 1);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_beats", 32'(m_beats), 0);

    // Two-beat frame
    step(1, 8'h3A, 0, 0, 0, 0);
    step(1, 8'h5F, 1, 0, 0, 0);
    check("two_beat_valid", 32'(m_valid), 1);
    check("two_beat_data", 32'(m_data), 32'h3);
    check("two_beat_beats", 32'(m_beats), 2);
    step(0, 8'h00, 0, 1, 0, 0);

    // Single beat held for three cycles with garbage inputs
    step(1, 8'hC6, 1, 0, 0, 0);
    check("single_data", 32'(m_data), 32'hA);
    check("single_beats", 32'(m_beats), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'($urandom), 1, 0, 0, 0);
      check("hold_data", 32'(m_data), 32'hA);
      check("hold_beats", 32'(m_beats), 1);
      check("hold_s_ready", 32'(s_ready), 0);
      check("hold_m_valid", 32'(m_valid), 1);
    end
    step(0, 8'h00, 0, 1, 0, 0);

    // Saturation
    for (int i = 0; i < 5; i++) step(1, 8'h01, i == 4, 0, 0, 0);
    check("sat_data", 32'(m_data), 32'h1);
    check("sat_beats", 32'(m_beats), 3);
    step(0, 8'h00, 0, 1, 0, 0);

    // Clear discards partial frame and the beat offered alongside it
    step(1, 8'h3A, 0, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 1, 0);
    step(1, 8'h10, 1, 0, 0, 0);
    check("clear_data", 32'(m_data), 32'h1);
    check("clear_beats", 32'(m_beats), 1);
    step(0, 8'h00, 0, 1, 0, 0);

    // Back-to-back with m_ready tied high; the beat offered in OUT is ignored
    step(1, 8'h3A, 1, 1, 0, 0);
    check("b2b_first", 32'(m_data), 32'h9);
    step(1, 8'h5F, 1, 1, 0, 0);
    check("b2b_out_no_accept", 32'(m_valid), 0);
    step(1, 8'h5F, 1, 1, 0, 0);
    check("b2b_second", 32'(m_data), 32'hA);
    step(0, 8'h00, 0, 1, 0, 0);
    check("b2b_done", 32'(m_valid), 0);

    // Reset while a result is pending
    step(1, 8'h3A, 1, 0, 0, 0);
    step(1, 8'hFF, 1, 1, 1, 1);
    check("rst_out_m_valid", 32'(m_valid), 0);
    check("rst_out_m_data", 32'(m_data), 0);
    check("rst_out_s_ready", 32'(s_ready), 1);
    step(1, 8'h5F, 1, 0, 0, 0);
    check("rst_out_next", 32'(m_data), 32'hA);
    step(0, 8'h00, 0, 1, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);

    check("results_delivered", 32'(received), 32'(pushed - dropped));
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
